// File: rtl/rr_grant_burst_mux.sv
// Burst multiplexer behind the round-robin arbiter: locks one granted requester onto the shared
// stream for len+1 beats, then pulses done back to the arbiter and holds off for one gap cycle.
module rr_grant_burst_mux #(
   parameter int unsigned SLAVE_COUNT = 4,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned LEN_WIDTH   = 4,
   localparam int unsigned IDX_WIDTH  = $clog2(SLAVE_COUNT)
) (
   input  logic                              clock,
   input  logic                              aresetn,
   input  logic [SLAVE_COUNT-1:0]            grant,
   input  logic [SLAVE_COUNT-1:0]            req_valid,
   input  logic [SLAVE_COUNT*DATA_WIDTH-1:0] req_data,
   input  logic [SLAVE_COUNT*LEN_WIDTH-1:0]  req_len,
   output logic [SLAVE_COUNT-1:0]            req_ready,
   output logic [SLAVE_COUNT-1:0]            done,
   output logic                              grant_err,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [DATA_WIDTH-1:0]             m_data,
   output logic [IDX_WIDTH-1:0]              m_id,
   output logic                              m_last
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StXfer = 2'd1;
   localparam logic [1:0] StDone = 2'd2;
   localparam logic [1:0] StGap  = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
   logic [SLAVE_COUNT-1:0] done_q, done_d;
   logic                   grant_err_q, grant_err_d;

   logic                   grant_onehot;
   logic                   grant_multi;
   logic [IDX_WIDTH-1:0]   grant_idx;
   logic [LEN_WIDTH-1:0]   grant_len;
   logic                   sel_valid;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic                   in_xfer;
   logic                   beat;

   // Grant decode: one-hot test plus binary index and that requester's length field.
   always_comb begin
      grant_onehot = (grant != '0) && ((grant & (grant - SLAVE_COUNT'(1))) == '0);
      grant_multi  = (grant != '0) && !grant_onehot;
      grant_idx    = '0;
      for (int i = 0; i < SLAVE_COUNT; i++) begin
         if (grant[i]) begin
            grant_idx = IDX_WIDTH'(i);
         end
      end
      grant_len = '0;
      for (int i = 0; i < SLAVE_COUNT; i++) begin
         if (grant_idx == IDX_WIDTH'(i)) begin
            grant_len = req_len[i*LEN_WIDTH +: LEN_WIDTH];
         end
      end
   end

   // Locked requester select.
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < SLAVE_COUNT; i++) begin
         if (idx_q == IDX_WIDTH'(i)) begin
            sel_valid = req_valid[i];
            sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      in_xfer = (state_q == StXfer);
      m_valid = in_xfer && sel_valid;
      m_data  = in_xfer ? sel_data : '0;
      m_last  = m_valid && (beat_cnt_q == len_q);
      m_id    = idx_q;
      beat    = m_valid && m_ready;
      for (int i = 0; i < SLAVE_COUNT; i++) begin
         req_ready[i] = in_xfer && (idx_q == IDX_WIDTH'(i)) && m_ready;
      end
      done      = done_q;
      grant_err = grant_err_q;
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      beat_cnt_d  = beat_cnt_q;
      done_d      = '0;
      grant_err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant_onehot) begin
               idx_d      = grant_idx;
               len_d      = grant_len;
               beat_cnt_d = '0;
               state_d    = StXfer;
            end else if (grant_multi) begin
               grant_err_d = 1'b1;
            end
         end
         StXfer: begin
            if (beat) begin
               if (m_last) begin
                  // Counter stays at len on the final beat so it can never wrap.
                  state_d = StDone;
                  for (int i = 0; i < SLAVE_COUNT; i++) begin
                     done_d[i] = (idx_q == IDX_WIDTH'(i));
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
               end
            end
         end
         StDone: begin
            state_d = StGap;
         end
         StGap: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         len_q       <= '0;
         beat_cnt_q  <= '0;
         done_q      <= '0;
         grant_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         beat_cnt_q  <= beat_cnt_d;
         done_q      <= done_d;
         grant_err_q <= grant_err_d;
      end
   end

endmodule
